serdes_ctrl: RTL
================

SERDES_CTRL -- requirements
Module: serdes_ctrl

Interface
REQ-001 Parameter FRAME_BITS, default 10: serial bits per encoded frame, which sets the SHIFT phase length.
REQ-002 Parameter CNT_W, default 4: bit-counter width; FRAME_BITS SHALL be <= 2**CNT_W and >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 link_en  input  1  enables acceptance of new frames.
REQ-006 tx_valid  input  1  upstream has a parallel byte ready for the latch.
REQ-007 tx_ready  output  1  controller accepts a frame this cycle.
REQ-008 data_en  output  1  one-cycle enable to the 8-bit input latch.
REQ-009 ser_en  output  1  one-cycle enable to the 8b/10b encoder.
REQ-010 load_en  output  1  one-cycle parallel load to the 10-bit PISO.
REQ-011 shift_en  output  1  shift enable to the 10-bit SIPO, held for FRAME_BITS cycles.
REQ-012 par_en  output  1  one-cycle enable to the 10b/8b decoder.
REQ-013 rx_valid  output  1  one-cycle pulse: decoded byte is available to the output register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_cnt  output  8  count of completed frames.

Function
REQ-016 The FSM SHALL have the states IDLE, LATCH, ENCODE, LOAD, SHIFT, DECODE and DONE, held in a state register.
REQ-017 tx_ready SHALL equal link_en AND (state==IDLE OR state==DONE); it is the only output with a combinational input path.
REQ-018 A handshake occurs when tx_valid AND tx_ready are both high in a cycle; the next state SHALL then be LATCH.
REQ-019 In IDLE with no handshake, the FSM SHALL remain in IDLE.
REQ-020 The unconditional transitions SHALL be: LATCH->ENCODE, ENCODE->LOAD, LOAD->SHIFT.
REQ-021 SHIFT SHALL last exactly FRAME_BITS cycles, counted by bit_cnt (CNT_W bits), which is cleared on entry and increments each SHIFT cycle.
REQ-022 When bit_cnt==FRAME_BITS-1, the FSM SHALL go to DECODE; there SHALL be no wrap beyond that value.
REQ-023 DECODE SHALL go to DONE.
REQ-024 DONE SHALL go to LATCH on a handshake, giving back-to-back frames; otherwise it SHALL go to IDLE.
REQ-025 Moore output decode SHALL be: data_en=LATCH, ser_en=ENCODE, load_en=LOAD, shift_en=SHIFT, par_en=DECODE, rx_valid=DONE. At most one of these SHALL be high in any cycle.
REQ-026 Latency: a handshake at cycle T SHALL produce rx_valid at cycle T+FRAME_BITS+5 (T+15 at default).
REQ-027 Throughput: with back-to-back frames, one frame SHALL complete every FRAME_BITS+5 cycles.
REQ-028 frame_cnt SHALL increment by 1 modulo 256 in each DONE cycle, wrapping 255->0.
REQ-029 Deasserting link_en mid-frame SHALL NOT abort the frame; it completes through DONE, after which the FSM goes to IDLE because there is no handshake.
REQ-030 tx_valid asserted while busy (outside DONE) SHALL be ignored and SHALL NOT be queued.

Reset
REQ-031 When rst_n is low at a clock edge: state SHALL become IDLE, bit_cnt 0, frame_cnt 0.
REQ-032 While state is IDLE after reset, all one-cycle enables, rx_valid and busy SHALL be 0, and tx_ready SHALL follow link_en.
REQ-033 Reset asserted in any state, including mid-SHIFT, SHALL abandon the frame on the next edge without producing an rx_valid pulse.

Verification
REQ-034 Single frame: link_en=1, tx_valid pulsed at T=5 -> data_en@6, ser_en@7, load_en@8, shift_en@9..18, par_en@19, rx_valid@20, frame_cnt=1.
REQ-035 Back-to-back: tx_valid held high for 3 frames -> rx_valid at T+15, T+30, T+45, busy never low between them, frame_cnt=3.
REQ-036 Flow gating: link_en=0 with tx_valid=1 for 20 cycles -> tx_ready=0, state stays IDLE. Then link_en=1 -> handshake on that cycle.
REQ-037 Mid-frame disable: link_en dropped during SHIFT -> the frame completes (rx_valid once), then IDLE, with tx_ready=0.
REQ-038 Reset mid-SHIFT at bit_cnt=4 -> next cycle IDLE, all enables 0, frame_cnt=0, and no rx_valid.
REQ-039 Wrap: run 256 frames -> frame_cnt returns to 0; a one-hot check on the enables holds throughout.

Source files
------------

// File: rtl/serdes_ctrl.sv
// serdes_ctrl -- sequencing controller for an 8b/10b serializer/deserializer
// datapath. One accepted byte walks through latch, encode, PISO load, a
// FRAME_BITS-long shift phase, decode and a final output-valid cycle.
//
// Ports:
//   clk        single clock, all state on its rising edge
//   rst_n      synchronous active-low reset
//   link_en    allows new frames to be accepted
//   tx_valid   upstream byte is available
//   tx_ready   frame accepted this cycle (combinational from link_en)
//   data_en    one-cycle enable to the 8-bit input latch
//   ser_en     one-cycle enable to the 8b/10b encoder
//   load_en    one-cycle parallel load to the PISO
//   shift_en   shift enable, high for FRAME_BITS cycles
//   par_en     one-cycle enable to the 10b/8b decoder
//   rx_valid   one-cycle pulse, decoded byte available
//   busy       high in every state except IDLE
//   frame_cnt  completed-frame count, wraps modulo 256
module serdes_ctrl #(
  parameter int FRAME_BITS = 10,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_en,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_en,
  output logic       ser_en,
  output logic       load_en,
  output logic       shift_en,
  output logic       par_en,
  output logic       rx_valid,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ENCODE,
    LOAD,
    SHIFT,
    DECODE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]       frame_cnt_reg;
  logic             handshake;

  // Accepting in DONE as well as IDLE lets frames run back to back with
  // no idle bubble between them.
  assign tx_ready  = link_en && ((state_reg == IDLE) || (state_reg == DONE));
  assign handshake = tx_valid && tx_ready;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      if (state_reg == DONE) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    data_en      = 1'b0;
    ser_en       = 1'b0;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    par_en       = 1'b0;
    rx_valid     = 1'b0;
    busy         = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (handshake) state_next = LATCH;
      end
      LATCH: begin
        data_en    = 1'b1;
        state_next = ENCODE;
      end
      ENCODE: begin
        ser_en     = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        load_en      = 1'b1;
        bit_cnt_next = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        // Counter stops at the last bit; it is re-cleared in LOAD, so it
        // never wraps inside a frame.
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = DECODE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      DECODE: begin
        par_en     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        rx_valid   = 1'b1;
        state_next = handshake ? LATCH : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
